// File: rtl/responder_pkg.sv
// Shared types and helpers for the responder answer-window timer.
package responder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} timer_state_t;

    localparam logic [3:0] BCD_BLANK = 4'hA;

    function automatic logic bcd_valid(input logic [3:0] nibble);
        return nibble <= 4'd9;
    endfunction

    // Elaboration-time binary to BCD, up to four digits, digit 0 in the LSBs.
    function automatic logic [15:0] bin_to_bcd(input int unsigned value);
        int unsigned v;
        logic [15:0] r;
        v = value;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the countdown: decrements when enabled, borrows out on 0 -> 9.
module bcd_digit_dec (
    input  logic [3:0] d,
    input  logic       dec_en,
    output logic [3:0] q,
    output logic       borrow
);

    always_comb begin
        q      = d;
        borrow = 1'b0;
        if (dec_en) begin
            if (d == 4'd0) begin
                q      = 4'd9;
                borrow = 1'b1;
            end else begin
                q = d - 4'd1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer_bcd.sv
// Answer-window BCD countdown with pause, runtime preset, buzzer and lockout.
// Define TIMER_WARN_EN to add short warning beeps during the last three seconds.
module countdown_timer_bcd
    import responder_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TICK_DIV       = CLK_HZ,
    parameter int DIGITS         = 2,
    parameter int DEFAULT_PRESET = 9,
    parameter int BUZZ_TICKS     = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Start,
    input  logic                Pause,
    input  logic                Clear,
    input  logic                Set_Time,
    input  logic [4*DIGITS-1:0] Set_Val,
    output logic [4*DIGITS-1:0] Timer_Digits,
    output logic                Running,
    output logic                Time_Over,
    output logic                Buzzer_TimeOver,
    output logic                LED_OverTime,
    output logic                Block_Sel
);

    localparam int NW = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(BUZZ_TICKS + 1);

    localparam logic [15:0]   DEF_BCD16 = bin_to_bcd(DEFAULT_PRESET);
    localparam logic [NW-1:0] DEF_BCD   = DEF_BCD16[NW-1:0];
    localparam logic [NW-1:0] BLANK_ALL = {DIGITS{BCD_BLANK}};
    localparam logic [PW-1:0] PS_LAST   = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BUZZ_INIT = BW'(BUZZ_TICKS);

    timer_state_t  state, state_n;
    logic [NW-1:0] preset, count_dec, count_n;
    logic [PW-1:0] presc, presc_n;
    logic [BW-1:0] buzz_cnt, buzz_n;
    logic          tick, do_expire, set_ok, warn;
    logic          blk_n, tov_n, buzz_o_n;
    logic [DIGITS:0] dec_en;
    logic          unused_borrow;

    assign tick      = (presc == PS_LAST);
    assign dec_en[0] = tick;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit_dec u_dig (
            .d      (Timer_Digits[4*i +: 4]),
            .dec_en (dec_en[i]),
            .q      (count_dec[4*i +: 4]),
            .borrow (dec_en[i+1])
        );
    end
    assign unused_borrow = dec_en[DIGITS];

    always_comb begin
        set_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (!bcd_valid(Set_Val[4*i +: 4])) set_ok = 1'b0;
    end

    always_comb begin
        state_n   = state;
        count_n   = Timer_Digits;
        presc_n   = presc;
        buzz_n    = buzz_cnt;
        blk_n     = Block_Sel;
        tov_n     = 1'b0;
        do_expire = 1'b0;
        case (state)
            IDLE: begin
                presc_n = '0;
                if (Start) begin
                    if (preset == '0) begin
                        do_expire = 1'b1;
                    end else begin
                        state_n = RUN;
                        count_n = preset;
                    end
                end
            end
            RUN, PAUSED: begin
                // PAUSED is left as soon as Pause drops, so the held phase resumes that cycle.
                if (Pause) begin
                    state_n = PAUSED;
                end else begin
                    state_n = RUN;
                    presc_n = tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        count_n = count_dec;
                        if (count_dec == '0) do_expire = 1'b1;
                    end
                end
            end
            EXPIRED: begin
                presc_n = tick ? '0 : presc + 1'b1;
                if (tick && buzz_cnt != '0) buzz_n = buzz_cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (do_expire) begin
            state_n = EXPIRED;
            count_n = '0;
            presc_n = '0;
            buzz_n  = BUZZ_INIT;
            blk_n   = 1'b1;
            tov_n   = 1'b1;
        end
        if (Clear) begin
            state_n = IDLE;
            count_n = BLANK_ALL;
            presc_n = '0;
            buzz_n  = '0;
            blk_n   = 1'b0;
            tov_n   = 1'b0;
        end
    end

`ifdef TIMER_WARN_EN
    localparam int WARN_CYC = TICK_DIV / 8;
    assign warn = (state_n == RUN) && (count_n != '0) && (count_n <= NW'(3)) &&
                  (int'(presc_n) < WARN_CYC);
`else
    assign warn = 1'b0;
`endif

    assign buzz_o_n = ((state_n == EXPIRED) && (buzz_n != '0)) || warn;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= IDLE;
            preset          <= DEF_BCD;
            presc           <= '0;
            buzz_cnt        <= '0;
            Timer_Digits    <= BLANK_ALL;
            Running         <= 1'b0;
            Time_Over       <= 1'b0;
            Buzzer_TimeOver <= 1'b0;
            LED_OverTime    <= 1'b0;
            Block_Sel       <= 1'b0;
        end else begin
            state           <= state_n;
            presc           <= presc_n;
            buzz_cnt        <= buzz_n;
            Timer_Digits    <= count_n;
            Running         <= (state_n == RUN) || (state_n == PAUSED);
            Time_Over       <= tov_n;
            Buzzer_TimeOver <= buzz_o_n;
            LED_OverTime    <= buzz_o_n;
            Block_Sel       <= blk_n;
            if (Set_Time && set_ok) preset <= Set_Val;
        end
    end

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed and random stimulus against an integer-seconds reference model of the timer.
module tb_countdown_timer_bcd;

    localparam int TD  = 4;
    localparam int ND  = 2;
    localparam int BT  = 2;
    localparam int DEF = 9;
    localparam int NW  = 4 * ND;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          Start = 1'b0, Pause = 1'b0, Clear = 1'b0, Set_Time = 1'b0;
    logic [NW-1:0] Set_Val = '0;
    logic [NW-1:0] Timer_Digits;
    logic          Running, Time_Over, Buzzer_TimeOver, LED_OverTime, Block_Sel;

    int n_chk = 0;
    int n_err = 0;

    // mode: 0 idle, 1 run, 2 paused, 3 expired; buzz counts remaining buzzer cycles
    int m_mode, m_secs, m_phase, m_buzz, m_preset;
    bit m_block, m_tov;

    countdown_timer_bcd #(
        .CLK_HZ(50_000_000), .TICK_DIV(TD), .DIGITS(ND),
        .DEFAULT_PRESET(DEF), .BUZZ_TICKS(BT)
    ) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Pause(Pause), .Clear(Clear),
        .Set_Time(Set_Time), .Set_Val(Set_Val), .Timer_Digits(Timer_Digits),
        .Running(Running), .Time_Over(Time_Over), .Buzzer_TimeOver(Buzzer_TimeOver),
        .LED_OverTime(LED_OverTime), .Block_Sel(Block_Sel)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NW-1:0] to_disp(input int v);
        logic [NW-1:0] r;
        int x;
        x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic m_expire();
        m_mode  = 3;
        m_secs  = 0;
        m_phase = 0;
        m_tov   = 1;
        m_block = 1;
        m_buzz  = BT * TD;
    endtask

    task automatic model_step();
        int old_preset, val, scale;
        bit ok;
        if (RST) begin
            m_mode = 0; m_secs = 0; m_phase = 0; m_buzz = 0;
            m_preset = DEF; m_block = 0; m_tov = 0;
        end else begin
            old_preset = m_preset;
            if (Set_Time) begin
                ok = 1; val = 0; scale = 1;
                for (int i = 0; i < ND; i++) begin
                    if (Set_Val[4*i +: 4] > 4'd9) ok = 0;
                    val += int'(Set_Val[4*i +: 4]) * scale;
                    scale *= 10;
                end
                if (ok) m_preset = val;
            end
            m_tov = 0;
            if (Clear) begin
                m_mode = 0; m_phase = 0; m_buzz = 0; m_block = 0;
            end else begin
                case (m_mode)
                    0: begin
                        m_phase = 0;
                        if (Start) begin
                            if (old_preset == 0) m_expire();
                            else begin m_mode = 1; m_secs = old_preset; end
                        end
                    end
                    1, 2: begin
                        if (Pause) m_mode = 2;
                        else begin
                            m_mode = 1;
                            if (m_phase == TD - 1) begin
                                m_phase = 0;
                                m_secs--;
                                if (m_secs == 0) m_expire();
                            end else m_phase++;
                        end
                    end
                    default: begin
                        m_phase = (m_phase + 1) % TD;
                        if (m_buzz > 0) m_buzz--;
                    end
                endcase
            end
        end
    endtask

    task automatic compare();
        logic [NW-1:0] exp_d;
        logic [NW-1:0] blank;
        blank = {ND{4'hA}};
        exp_d = (m_mode == 0) ? blank : to_disp(m_secs);
        chk("digits",  Timer_Digits,    exp_d);
        chk("running", Running,         (m_mode == 1 || m_mode == 2));
        chk("tov",     Time_Over,       m_tov);
        chk("buzzer",  Buzzer_TimeOver, (m_mode == 3 && m_buzz > 0));
        chk("led",     LED_OverTime,    (m_mode == 3 && m_buzz > 0));
        chk("block",   Block_Sel,       m_block);
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare();
    endtask

    initial begin
        RST = 1'b1;
        cycle(); cycle();
        chk("rst_digits", Timer_Digits, 8'hAA);
        chk("rst_block", Block_Sel, 1'b0);
        RST = 1'b0;

        // default preset countdown through expiry and full buzzer window
        Start = 1'b1; cycle(); Start = 1'b0;
        chk("start_load", Timer_Digits, 8'h09);
        repeat (9*TD + BT*TD + 4) cycle();
        chk("lock_held", Block_Sel, 1'b1);
        Clear = 1'b1; cycle(); Clear = 1'b0;
        chk("clear_lock", Block_Sel, 1'b0);

        // valid preset taken, invalid one ignored
        Set_Val = 8'h12; Set_Time = 1'b1; cycle();
        Set_Val = 8'h1B; cycle(); Set_Time = 1'b0;
        Start = 1'b1; cycle(); Start = 1'b0;
        chk("preset_kept", Timer_Digits, 8'h12);
        repeat (3*TD) cycle();
        chk("borrow", Timer_Digits, 8'h09);

        // pause two cycles into a second, for ten cycles
        repeat (2) cycle();
        Pause = 1'b1; repeat (10) cycle(); Pause = 1'b0;
        chk("pause_hold", Timer_Digits, 8'h09);
        cycle();
        chk("resume_phase", Timer_Digits, 8'h09);
        cycle();
        chk("resume_tick", Timer_Digits, 8'h08);

        Clear = 1'b1; Start = 1'b1; cycle(); Clear = 1'b0; Start = 1'b0;
        chk("clr_start_blank", Timer_Digits, 8'hAA);
        chk("clr_start_idle", Running, 1'b0);
        Start = 1'b1; Pause = 1'b1; cycle(); Start = 1'b0; Pause = 1'b0;
        chk("start_pause_run", Running, 1'b1);
        repeat (3) cycle();
        Clear = 1'b1; cycle(); Clear = 1'b0;

        // zero preset expires immediately; reset during buzzer
        Set_Val = 8'h00; Set_Time = 1'b1; cycle(); Set_Time = 1'b0;
        Start = 1'b1; cycle(); Start = 1'b0;
        chk("zero_tov", Time_Over, 1'b1);
        chk("zero_digits", Timer_Digits, 8'h00);
        cycle();
        chk("tov_one_cycle", Time_Over, 1'b0);
        cycle();
        RST = 1'b1; cycle(); RST = 1'b0;
        chk("rst_buzz", Buzzer_TimeOver, 1'b0);
        chk("rst_blank", Timer_Digits, 8'hAA);
        Start = 1'b1; cycle(); Start = 1'b0;
        chk("rst_preset", Timer_Digits, 8'h09);

        // random mix
        repeat (2000) begin
            Start    = ($urandom_range(15) == 0);
            Clear    = ($urandom_range(60) == 0);
            Set_Time = ($urandom_range(20) == 0);
            Set_Val  = ($urandom_range(1) == 0) ? to_disp($urandom_range(12)) : NW'($urandom);
            RST      = ($urandom_range(400) == 0);
            if ($urandom_range(9) == 0) Pause = ~Pause;
            cycle();
        end
        Start = 1'b0; Clear = 1'b0; Set_Time = 1'b0; RST = 1'b0; Pause = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
